// File: rtl/ffram_wb_pkg.sv
// ----------------------------------------------------------------------------
// ffram_wb_pkg
// Shared types and helpers for the banked flip-flop RAM Wishbone slave.
//   state_t      : request/response FSM states
//   WAIT_CNT_W   : width of the wait-state / response-alignment down-counter
//   SEL_TO_MASK  : expands 4 byte-lane enables into a 32-bit bit mask
// ----------------------------------------------------------------------------
package ffram_wb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int WAIT_CNT_W = 3;

    function automatic logic [31:0] SEL_TO_MASK(input logic [3:0] sel);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ffram_wb_banked_ffram.sv
// ----------------------------------------------------------------------------
// ffram
// Flip-flop RAM bank: WORD_NUM words of WORD_W bits, no reset on contents.
// Ports:
//   vccd1/vssd1 : power pins (USE_POWER_PINS only)
//   clk_i       : clock
//   wb_en_i     : bank enable
//   r_en_i      : 1 = read, 0 = write (write commits at the clock edge)
//   bit_en_i    : per-bit write enable
//   addr_i      : word address
//   d_in_i      : write data
//   d_out_o     : read data, combinational from addr_i
// ----------------------------------------------------------------------------
module ffram #(
    parameter int WORD_NUM = 128,
    parameter int WORD_W   = 32
) (
`ifdef USE_POWER_PINS
    inout                              vccd1,
    inout                              vssd1,
`endif
    input  logic                        clk_i,
    input  logic                        wb_en_i,
    input  logic                        r_en_i,
    input  logic [WORD_W-1:0]           bit_en_i,
    input  logic [$clog2(WORD_NUM)-1:0] addr_i,
    input  logic [WORD_W-1:0]           d_in_i,
    output logic [WORD_W-1:0]           d_out_o
);

    logic [WORD_W-1:0] mem_q [WORD_NUM];

    always_ff @(posedge clk_i) begin
        if (wb_en_i && !r_en_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~bit_en_i) | (d_in_i & bit_en_i);
        end
    end

    assign d_out_o = mem_q[addr_i];

endmodule

// File: rtl/ffram_wb_banked.sv
// ----------------------------------------------------------------------------
// ffram_wb_banked
// Wishbone B4 classic slave mapping BANKS ffram banks into one contiguous
// word-addressed window at BASE_ADDR, with error response on misses,
// programmable read wait states, cycle abort and byte-lane writes.
// Ports:
//   wb_clk_i, wb_rst_i (async, active-high)
//   vccd1/vssd1 (USE_POWER_PINS only), passed through to every bank
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0],
//   wbs_dat_i[31:0]  : bus request
//   wbs_ack_o, wbs_err_o, wbs_dat_o[31:0] : bus response
// ----------------------------------------------------------------------------
module ffram_wb_banked
    import ffram_wb_pkg::*;
#(
    parameter int          BANKS       = 2,
    parameter int          WORD_NUM    = 128,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          WAIT_STATES = 0
) (
`ifdef USE_POWER_PINS
    inout               vccd1,
    inout               vssd1,
`endif
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o
);

    localparam int          ROW_W     = $clog2(WORD_NUM);
    localparam int          BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(BANKS * WORD_NUM * 4);

    // Window decode; a negative offset wraps to a large value and misses.
    logic [31:0]       off;
    logic              hit;
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;

    assign off  = wbs_adr_i - BASE_ADDR;
    assign hit  = off < WIN_BYTES;
    assign row  = off[2 +: ROW_W];
    assign bank = off[2+ROW_W +: BANK_W];

    logic unused_off;
    assign unused_off = &{1'b0, off};

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           wdat_q, wdat_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  hit_q, hit_d;
    logic [31:0]           rdat_q, rdat_d;

    logic [BANKS-1:0]      wb_en;
    logic [31:0]           d_out [BANKS];
    logic [31:0]           rd_word;
    logic                  bank_active;

    // Reads keep the bank enabled through the wait states.
    assign bank_active = wbs_cyc_i && hit_q &&
                         ((state_q == ACC) || ((state_q == WAIT) && !we_q));

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        assign wb_en[g] = bank_active && (bank_q == BANK_W'(g));

        ffram #(
            .WORD_NUM (WORD_NUM),
            .WORD_W   (32)
        ) u_ffram (
`ifdef USE_POWER_PINS
            .vccd1    (vccd1),
            .vssd1    (vssd1),
`endif
            .clk_i    (wb_clk_i),
            .wb_en_i  (wb_en[g]),
            .r_en_i   (~we_q),
            .bit_en_i (SEL_TO_MASK(sel_q)),
            .addr_i   (row_q),
            .d_in_i   (wdat_q),
            .d_out_o  (d_out[g])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (bank_q == BANK_W'(b)) begin
                rd_word = d_out[b];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            hit_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            hit_q   <= hit_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        bank_d  = bank_q;
        row_d   = row_q;
        hit_d   = hit_q;
        rdat_d  = rdat_q;

        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    we_d   = wbs_we_i;
                    sel_d  = wbs_sel_i;
                    wdat_d = wbs_dat_i;
                    bank_d = bank;
                    row_d  = row;
                    hit_d  = hit;
                    if (hit) begin
                        state_d = ACC;
                    end else begin
                        // ERR spends one silent cycle so err lands on the
                        // same edge a write ack would.
                        state_d = ERR;
                        cnt_d   = WAIT_CNT_W'(1);
                    end
                end
            end
            ACC: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (we_q) begin
                    state_d = RESP;
                end else if (WAIT_STATES == 0) begin
                    state_d = RESP;
                    rdat_d  = rd_word;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    rdat_d  = rd_word;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            ERR: begin
                if (!wbs_cyc_i || (cnt_q == '0)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wbs_ack_o = (state_q == RESP) && wbs_cyc_i;
    assign wbs_err_o = (state_q == ERR) && (cnt_q == '0) && wbs_cyc_i;
    assign wbs_dat_o = rdat_q;

endmodule
